systolic_mac_pe: RTL and testbench
==================================

SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width.
REQ-002 SHALL have parameter ACC_W, default 40, accumulator/result width (ACC_W >= 2*DATA_W).
REQ-003 SHALL have parameter SIGNED, default 1; 1 means two's-complement operands, 0 means unsigned.
REQ-004 SHALL have parameter SATURATE, default 1; 1 means clamp on overflow, 0 means wrap.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port nreset, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have ports a_in, b_in, input, DATA_W, operands; and a_out, b_out, output, DATA_W, forwarded operands.
REQ-008 SHALL have ports in_valid, first_in, last_in, input, 1, beat valid and dot-product start/end markers; and out_valid, first_out, last_out, output, 1, their forwarded copies.
REQ-009 SHALL have ports drain_in, input, ACC_W, upstream result, with drain_in_valid, input, 1, and drain_in_ready, output, 1.
REQ-010 SHALL have ports drain_out, output, ACC_W, result, with drain_out_valid, output, 1, and drain_out_ready, input, 1.
REQ-011 SHALL have ports ovf, output, 1, sticky arithmetic saturation/wrap flag; and res_lost, output, 1, sticky dropped-result flag.

Function
REQ-012 SHALL register a_in, b_in, in_valid, first_in and last_in to their _out ports with exactly 1-cycle latency, every cycle, independent of state or drain backpressure.
REQ-013 SHALL form the product as a full 2*DATA_W product, signed or unsigned per SIGNED, extended to ACC_W.
REQ-014 SHALL run FSM states IDLE, ACCUM and HOLD on an accepted beat (in_valid=1):
- IDLE or ACCUM with first_in=1: acc = product.
- IDLE with first_in=0: acc = 0 + product.
- Otherwise: acc = acc + product.
- last_in=1: goes to HOLD, or IDLE if a result is already held; else goes to ACCUM.
REQ-015 SHALL, when SATURATE=1, clamp each sum to the ACC_W min/max and set ovf; when SATURATE=0, wrap modulo 2^ACC_W and set ovf on signed/unsigned overflow.
REQ-016 SHALL, on a beat with last_in=1, copy the final sum into the result register if it is empty; otherwise drop it, keep the held result and set res_lost.
REQ-017 SHALL accept new beats in every state, including while a result is held, because the accumulator and result register are independent.
REQ-018 SHALL, on first_in=1 during ACCUM, discard the partial sum and restart.
REQ-019 SHALL treat first_in=last_in=1 on one beat as a single-term result.
REQ-020 SHALL load the drain_out register when drain_out_valid=0 or drain_out_ready=1.
- Source priority: own held result, then drain_in when drain_in_valid=1.
- If neither source is available, drain_out_valid goes to 0.
REQ-021 SHALL drive drain_in_ready = (drain_out_valid=0 or drain_out_ready=1) and no own result held; drain_in_ready is combinational.
REQ-022 SHALL hold drain_out and drain_out_valid stable while drain_out_valid=1 and drain_out_ready=0.
REQ-023 SHALL free the result register on the cycle its value is loaded into drain_out; the FSM leaves HOLD then.
REQ-024 SHALL clear ovf and res_lost only by reset.

Reset
REQ-025 SHALL, when nreset=0 at a rising clock edge, set state IDLE, acc 0, result register empty, and all outputs (a_out, b_out, out_valid, first_out, last_out, drain_out, drain_out_valid, ovf, res_lost) to 0.
REQ-026 SHALL, on reset mid-accumulation or mid-drain, discard partial sums and held results without emitting them.

Structure
REQ-027 SHALL place the FSM state enum and the saturation min/max helper constants in shared package systolic_pkg.
REQ-028 SHALL use exactly one sub-module, sat_add, a parametrised ACC_W adder with SIGNED/SATURATE behaviour that outputs sum and overflow.

Verification
REQ-029 SHALL cover: DATA_W=16, SIGNED=1, beats (3,4)first, (-2,5), (7,1)last -> drain_out=9, drain_out_valid=1 within 2 cycles of last; a_out/b_out trail a_in/b_in by 1 cycle.
REQ-030 SHALL cover: SATURATE=1, ACC_W=32, repeated (32767,32767) beats -> acc clamps at 2147483647, ovf=1; with SATURATE=0 -> wraps negative, ovf=1.
REQ-031 SHALL cover: own result 10 held with drain_in_valid=1 carrying 55 -> drain_out emits 10, then 55; drain_in_ready=0 while 10 is held.
REQ-032 SHALL cover: drain_out_ready=0 for 5 cycles -> drain_out stable; a second last beat drops its result, res_lost=1, first result intact.
REQ-033 SHALL cover: first_in=last_in=1 with (6,-3) -> result -18; first_in mid-ACCUM discards the partial sum.
REQ-034 SHALL cover: nreset=0 for one cycle mid-ACCUM with a result held -> all outputs 0 next cycle, nothing drained.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and saturation bound helpers for the systolic MAC PE.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam int MAX_W = 128;
    function automatic logic [MAX_W-1:0] sat_max(input int w, input bit sgn);
        logic [MAX_W-1:0] one;
        one = 1;
        return sgn ? (one << (w - 1)) - one : (one << w) - one;
    endfunction
    function automatic logic [MAX_W-1:0] sat_min(input int w, input bit sgn);
        logic [MAX_W-1:0] one;
        one = 1;
        return sgn ? one << (w - 1) : '0;
    endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: W-bit adder that clamps or wraps on overflow and reports the overflow.
module sat_add
    import systolic_pkg::*;
#(
    parameter int W        = 40,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0]   raw;
    logic [W-1:0] mx, mn;
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        mx  = W'(sat_max(W, SIGNED != 0));
        mn  = W'(sat_min(W, SIGNED != 0));
        ovf = (SIGNED != 0) ? (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]) : raw[W];
        sum = !((SATURATE != 0) && ovf) ? raw[W-1:0] : ((SIGNED != 0) && a[W-1]) ? mn : mx;
    end
endmodule

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: systolic-array MAC cell with operand forwarding and a chained result drain.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    input  logic              first_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              out_valid,
    output logic              first_out,
    output logic              last_out,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_in_valid,
    output logic              drain_in_ready,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_out_valid,
    input  logic              drain_out_ready,
    output logic              ovf,
    output logic              res_lost
);
    localparam int PW = 2 * DATA_W;
    state_t              state;
    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]       prod_u;
    logic [ACC_W-1:0]    ext_s, ext_u, prod_ext, base, sum, acc, res;
    logic                sum_ovf, res_full, load, res_take, res_free;
    always_comb begin
        prod_s         = $signed(a_in) * $signed(b_in);
        prod_u         = a_in * b_in;
        ext_s          = ACC_W'(prod_s);
        ext_u          = ACC_W'(prod_u);
        prod_ext       = (SIGNED != 0) ? ext_s : ext_u;
        base           = (state != IDLE && !first_in) ? acc : '0;
        load           = !drain_out_valid || drain_out_ready;
        res_take       = load && res_full;
        res_free       = !res_full || res_take;
        drain_in_ready = load && !res_full;
    end
    sat_add #(.W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_add (
        .a(base), .b(prod_ext), .sum(sum), .ovf(sum_ovf)
    );
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state           <= IDLE;
            acc             <= '0;
            res             <= '0;
            res_full        <= 1'b0;
            a_out           <= '0;
            b_out           <= '0;
            out_valid       <= 1'b0;
            first_out       <= 1'b0;
            last_out        <= 1'b0;
            drain_out       <= '0;
            drain_out_valid <= 1'b0;
            ovf             <= 1'b0;
            res_lost        <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            out_valid <= in_valid;
            first_out <= first_in;
            last_out  <= last_in;
            if (in_valid) begin
                acc   <= sum;
                ovf   <= ovf | sum_ovf;
                state <= !last_in ? ACCUM : res_free ? HOLD : IDLE;
            end else if (state == HOLD && res_take) begin
                state <= IDLE;
            end
            // A result being drained this cycle frees its slot for a same-cycle final sum.
            if (in_valid && last_in && res_free) begin
                res      <= sum;
                res_full <= 1'b1;
            end else if (res_take) begin
                res_full <= 1'b0;
            end
            if (in_valid && last_in && !res_free)
                res_lost <= 1'b1;
            if (load) begin
                drain_out_valid <= res_full || drain_in_valid;
                if (res_full)
                    drain_out <= res;
                else if (drain_in_valid)
                    drain_out <= drain_in;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb_systolic_mac_pe: directed scenario bench for systolic_mac_pe (saturating and wrapping instances).
module tb_systolic_mac_pe;
    logic        clock = 0;
    logic        nreset = 0;
    logic [15:0] a_in = 0, b_in = 0;
    logic        in_valid = 0, first_in = 0, last_in = 0;
    logic [15:0] a_out, b_out;
    logic        out_valid, first_out, last_out;
    logic [31:0] drain_in = 0;
    logic        drain_in_valid = 0, drain_in_ready;
    logic [31:0] drain_out;
    logic        drain_out_valid, drain_out_ready = 1;
    logic        ovf, res_lost;
    logic [15:0] w_a_out, w_b_out;
    logic        w_out_valid, w_first_out, w_last_out, w_drain_in_ready, w_drain_out_valid, w_ovf, w_res_lost;
    logic [31:0] w_drain_out;
    int cmp = 0, err = 0;

    always #5 clock = ~clock;

    systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1), .SATURATE(1)) dut (
        .clock(clock), .nreset(nreset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .first_in(first_in), .last_in(last_in), .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
        .first_out(first_out), .last_out(last_out), .drain_in(drain_in), .drain_in_valid(drain_in_valid),
        .drain_in_ready(drain_in_ready), .drain_out(drain_out), .drain_out_valid(drain_out_valid),
        .drain_out_ready(drain_out_ready), .ovf(ovf), .res_lost(res_lost)
    );
    systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1), .SATURATE(0)) dut_w (
        .clock(clock), .nreset(nreset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .first_in(first_in), .last_in(last_in), .a_out(w_a_out), .b_out(w_b_out), .out_valid(w_out_valid),
        .first_out(w_first_out), .last_out(w_last_out), .drain_in(drain_in), .drain_in_valid(drain_in_valid),
        .drain_in_ready(w_drain_in_ready), .drain_out(w_drain_out), .drain_out_valid(w_drain_out_valid),
        .drain_out_ready(drain_out_ready), .ovf(w_ovf), .res_lost(w_res_lost)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input int a, input int b, input bit f, input bit l);
        a_in = 16'(a); b_in = 16'(b); in_valid = 1; first_in = f; last_in = l;
        step();
        in_valid = 0; first_in = 0; last_in = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        nreset = 0;
        idle(2);
        nreset = 1;
        cmp++; if (a_out !== 16'd0) begin err++; $display("FAIL reset_a_out got %0h want 0", a_out); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        cmp++; if (drain_out_valid !== 1'b0) begin err++; $display("FAIL reset_dov got %b want 0", drain_out_valid); end
        cmp++; if (drain_out !== 32'd0) begin err++; $display("FAIL reset_drain_out got %0h want 0", drain_out); end
        cmp++; if ({ovf, res_lost} !== 2'b00) begin err++; $display("FAIL reset_flags got %b want 00", {ovf, res_lost}); end
        cmp++; if (drain_in_ready !== 1'b1) begin err++; $display("FAIL reset_din_ready got %b want 1", drain_in_ready); end
    endtask

    task automatic test_dot();
        drain_out_ready = 1;
        beat(3, 4, 1, 0);
        cmp++; if ({a_out, b_out} !== {16'd3, 16'd4}) begin err++; $display("FAIL fwd_ab got %0h/%0h want 3/4", a_out, b_out); end
        cmp++; if ({out_valid, first_out, last_out} !== 3'b110) begin err++; $display("FAIL fwd_flags got %b want 110", {out_valid, first_out, last_out}); end
        beat(-2, 5, 0, 0);
        cmp++; if ({a_out, b_out} !== {16'hFFFE, 16'd5}) begin err++; $display("FAIL fwd_ab2 got %0h/%0h want fffe/5", a_out, b_out); end
        beat(7, 1, 0, 1);
        cmp++; if ({out_valid, first_out, last_out} !== 3'b101) begin err++; $display("FAIL fwd_last got %b want 101", {out_valid, first_out, last_out}); end
        step();
        cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd9}) begin err++; $display("FAIL dot_result got %b/%0d want 1/9", drain_out_valid, drain_out); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL fwd_idle got %b want 0", out_valid); end
        step();
        cmp++; if (drain_out_valid !== 1'b0) begin err++; $display("FAIL dot_dov_clear got %b want 0", drain_out_valid); end
        cmp++; if (ovf !== 1'b0) begin err++; $display("FAIL dot_no_ovf got %b want 0", ovf); end
    endtask

    task automatic test_saturate();
        beat(32767, 32767, 1, 0);
        beat(32767, 32767, 0, 0);
        beat(32767, 32767, 0, 1);
        step();
        cmp++; if (drain_out !== 32'h7FFFFFFF) begin err++; $display("FAIL sat_clamp got %0h want 7fffffff", drain_out); end
        cmp++; if (ovf !== 1'b1) begin err++; $display("FAIL sat_ovf got %b want 1", ovf); end
        cmp++; if (w_drain_out !== 32'hBFFD0003) begin err++; $display("FAIL wrap_value got %0h want bffd0003", w_drain_out); end
        cmp++; if (w_ovf !== 1'b1) begin err++; $display("FAIL wrap_ovf got %b want 1", w_ovf); end
        step();
    endtask

    task automatic test_priority();
        beat(2, 5, 1, 1);
        drain_in = 32'd55; drain_in_valid = 1;
        #1;
        cmp++; if (drain_in_ready !== 1'b0) begin err++; $display("FAIL prio_din_ready_held got %b want 0", drain_in_ready); end
        step();
        cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd10}) begin err++; $display("FAIL prio_own got %b/%0d want 1/10", drain_out_valid, drain_out); end
        cmp++; if (drain_in_ready !== 1'b1) begin err++; $display("FAIL prio_din_ready_free got %b want 1", drain_in_ready); end
        step();
        drain_in_valid = 0;
        cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd55}) begin err++; $display("FAIL prio_upstream got %b/%0d want 1/55", drain_out_valid, drain_out); end
        step();
        cmp++; if (drain_out_valid !== 1'b0) begin err++; $display("FAIL prio_empty got %b want 0", drain_out_valid); end
    endtask

    task automatic test_backpressure();
        drain_out_ready = 0;
        beat(1, 8, 1, 1);
        step();
        beat(2, 2, 1, 1);
        cmp++; if (res_lost !== 1'b0) begin err++; $display("FAIL bp_no_loss got %b want 0", res_lost); end
        beat(3, 3, 1, 1);
        cmp++; if (res_lost !== 1'b1) begin err++; $display("FAIL bp_res_lost got %b want 1", res_lost); end
        for (int i = 0; i < 5; i++) begin
            cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd8}) begin err++; $display("FAIL bp_stable%0d got %b/%0d want 1/8", i, drain_out_valid, drain_out); end
            step();
        end
        drain_out_ready = 1;
        step();
        cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd4}) begin err++; $display("FAIL bp_held_intact got %b/%0d want 1/4", drain_out_valid, drain_out); end
        step();
        cmp++; if (drain_out_valid !== 1'b0) begin err++; $display("FAIL bp_empty got %b want 0", drain_out_valid); end
    endtask

    task automatic test_single_restart();
        beat(6, -3, 1, 1);
        step();
        cmp++; if (drain_out !== 32'hFFFFFFEE) begin err++; $display("FAIL single_term got %0h want ffffffee", drain_out); end
        beat(100, 100, 1, 0);
        beat(5, 5, 0, 0);
        beat(2, 3, 1, 0);
        beat(4, 1, 0, 1);
        step();
        cmp++; if ({drain_out_valid, drain_out} !== {1'b1, 32'd10}) begin err++; $display("FAIL restart got %b/%0d want 1/10", drain_out_valid, drain_out); end
        step();
    endtask

    task automatic test_reset_mid();
        drain_out_ready = 0;
        beat(1, 1, 1, 1);
        step();
        beat(2, 2, 1, 1);
        a_in = 16'd3; b_in = 16'd3; in_valid = 1; first_in = 1;
        step();
        nreset = 0;
        step();
        cmp++; if ({a_out, b_out, out_valid, first_out, last_out} !== 35'd0) begin err++; $display("FAIL rst_mid_fwd got %0h want 0", {a_out, b_out, out_valid, first_out, last_out}); end
        cmp++; if ({drain_out_valid, drain_out, ovf, res_lost} !== 35'd0) begin err++; $display("FAIL rst_mid_drain got %0h want 0", {drain_out_valid, drain_out, ovf, res_lost}); end
        nreset = 1; in_valid = 0; first_in = 0; drain_out_ready = 1;
        idle(3);
        cmp++; if ({drain_out_valid, drain_out} !== 33'd0) begin err++; $display("FAIL rst_mid_nothing got %b/%0h want 0/0", drain_out_valid, drain_out); end
        beat(2, 3, 0, 1);
        step();
        cmp++; if (drain_out !== 32'd6) begin err++; $display("FAIL rst_mid_acc_zero got %0d want 6", drain_out); end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_saturate();
        test_priority();
        test_backpressure();
        test_single_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
